qu_rob: RTL and testbench

In-order reorder buffer for the Qu out-of-order core; sits downstream of rename/dispatch and alongside the reservation stations.
- Allocates one entry per dispatched instruction and returns its ROB tag; reservation-station cells carry this tag as rob_addr/qj/qk.
- Tracks each entry through PENDING -> EXECUTE -> RETIRED.
- Captures results from the writeback bus.
- Commits completed entries strictly in program order to the physical register file.

---
 rtl/qu_rob.sv | 154 +++++++++++++++
 tb/tb_qu_rob.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qu_rob.sv
// rtl/qu_rob.sv - in-order reorder buffer: allocate, issue, writeback capture, in-order commit
module qu_rob #(
    parameter int ROB_DEPTH         = 8,
    parameter int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH),
    parameter int PHY_RF_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_dest,
    output logic                         alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]    alloc_addr,
    input  logic                         issue_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]    issue_addr,
    input  logic                         wb_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_value,
    output logic                         commit_valid,
    input  logic                         commit_ready,
    output logic [ROB_ADDR_WIDTH-1:0]    commit_addr,
    output logic [PHY_RF_ADDR_WIDTH-1:0] commit_dest,
    output logic [DATA_WIDTH-1:0]        commit_value,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [ROB_ADDR_WIDTH:0]      count,
    output logic                         wb_err
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_RETIRED = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_PENDING = 2'b11
    } cell_state_e;

    localparam logic [ROB_ADDR_WIDTH:0]   DEPTH_CNT = (ROB_ADDR_WIDTH+1)'(ROB_DEPTH);
    localparam logic [ROB_ADDR_WIDTH:0]   CNT_ONE   = {{ROB_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_ADDR_WIDTH-1:0] PTR_ONE   = {{(ROB_ADDR_WIDTH-1){1'b0}}, 1'b1};

    cell_state_e                  state_q [ROB_DEPTH];
    cell_state_e                  state_d [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]        value_q [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]        value_d [ROB_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0] dest_q  [ROB_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0] dest_d  [ROB_DEPTH];

    logic [ROB_ADDR_WIDTH-1:0] head_q, head_d;
    logic [ROB_ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_ADDR_WIDTH:0]   count_q, count_d;
    logic                      wb_err_q, wb_err_d;

    logic do_alloc;
    logic do_commit;

    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        count        = count_q;
        wb_err       = wb_err_q;
        // Space is judged on the registered count only, so a same-cycle commit never frees a slot.
        alloc_ready  = !full;
        alloc_addr   = tail_q;
        do_alloc     = alloc_req && alloc_ready;
        commit_valid = (state_q[head_q] == ST_RETIRED);
        do_commit    = commit_valid && commit_ready;
        commit_addr  = '0;
        commit_dest  = '0;
        commit_value = '0;
        if (commit_valid) begin
            commit_addr  = head_q;
            commit_dest  = dest_q[head_q];
            commit_value = value_q[head_q];
        end
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        dest_d   = dest_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wb_err_d = wb_err_q;

        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                state_d[i] = ST_EMPTY;
                value_d[i] = '0;
                dest_d[i]  = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit) begin
                state_d[head_q] = ST_EMPTY;
                value_d[head_q] = '0;
                head_d          = head_q + PTR_ONE;
            end

            if (issue_valid && (state_q[issue_addr] == ST_PENDING)) begin
                state_d[issue_addr] = ST_EXECUTE;
            end

            // Writeback qualifies on the registered state, so a same-cycle issue to this tag does not help it.
            if (wb_valid) begin
                if (state_q[wb_addr] == ST_EXECUTE) begin
                    state_d[wb_addr] = ST_RETIRED;
                    value_d[wb_addr] = wb_value;
                end else begin
                    wb_err_d = 1'b1;
                end
            end

            if (do_alloc) begin
                state_d[tail_q] = ST_PENDING;
                value_d[tail_q] = '0;
                dest_d[tail_q]  = alloc_dest;
                tail_d          = tail_q + PTR_ONE;
            end

            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                state_q[i] <= ST_EMPTY;
                value_q[i] <= '0;
                dest_q[i]  <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            dest_q   <= dest_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wb_err_q <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_qu_rob.sv
// tb/tb_qu_rob.sv - directed vector bench for qu_rob
module tb_qu_rob;

    logic        clk;
    logic        rst;
    logic        alloc_req;
    logic [6:0]  alloc_dest;
    logic        alloc_ready;
    logic [2:0]  alloc_addr;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_value;
    logic        commit_valid;
    logic        commit_ready;
    logic [2:0]  commit_addr;
    logic [6:0]  commit_dest;
    logic [31:0] commit_value;
    logic        flush;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    qu_rob dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_addr(commit_addr), .commit_dest(commit_dest), .commit_value(commit_value),
        .flush(flush), .full(full), .empty(empty), .count(count), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic [6:0]  ad;
        logic        iv;
        logic [2:0]  ia;
        logic        wv;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        cr;
        logic        rdy;
        logic [2:0]  aa;
        logic        cv;
        logic [2:0]  ca;
        logic [6:0]  cd;
        logic [31:0] cval;
        logic        full;
        logic        empty;
        logic [3:0]  cnt;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ar, input logic [6:0] ad, input logic iv, input logic [2:0] ia,
        input logic wv, input logic [2:0] wa, input logic [31:0] wd, input logic cr,
        input logic rdy, input logic [2:0] aa, input logic cv, input logic [2:0] ca,
        input logic [6:0] cd, input logic [31:0] cval, input logic fu, input logic em,
        input logic [3:0] cnt, input logic err);
        vec_t v;
        v.ar = ar; v.ad = ad; v.iv = iv; v.ia = ia; v.wv = wv; v.wa = wa; v.wd = wd; v.cr = cr;
        v.rdy = rdy; v.aa = aa; v.cv = cv; v.ca = ca; v.cd = cd; v.cval = cval;
        v.full = fu; v.empty = em; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic [6:0] ad, input logic iv, input logic [2:0] ia,
                         input logic wv, input logic [2:0] wa, input logic [31:0] wd,
                         input logic cr, input logic fl);
        alloc_req = ar; alloc_dest = ad; issue_valid = iv; issue_addr = ia;
        wb_valid = wv; wb_addr = wa; wb_value = wd; commit_ready = cr; flush = fl;
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        chk({p, ".alloc_ready"},  32'(alloc_ready),  32'(v.rdy));
        chk({p, ".alloc_addr"},   32'(alloc_addr),   32'(v.aa));
        chk({p, ".commit_valid"}, 32'(commit_valid), 32'(v.cv));
        chk({p, ".commit_addr"},  32'(commit_addr),  32'(v.ca));
        chk({p, ".commit_dest"},  32'(commit_dest),  32'(v.cd));
        chk({p, ".commit_value"}, commit_value,      v.cval);
        chk({p, ".full"},         32'(full),         32'(v.full));
        chk({p, ".empty"},        32'(empty),        32'(v.empty));
        chk({p, ".count"},        32'(count),        32'(v.cnt));
        chk({p, ".wb_err"},       32'(wb_err),       32'(v.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill to full, then a rejected 9th request
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 13, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 0, 0,   1, 4, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(mk(1, 16, 0, 0, 0, 0, 0, 0,   1, 6, 0, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(1, 17, 0, 0, 0, 0, 0, 0,   1, 7, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(1, 18, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8, 0));
        // Retire tags 0..2; commit at full with alloc rejected; then wrap allocs 0..2
        tbl.push_back(mk(0,  0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 1, 1, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 1, 2, 1, 1, 101, 0, 0, 0, 1, 0, 10, 100, 1, 0, 8, 0));
        tbl.push_back(mk(1, 99, 0, 0, 1, 2, 102, 1, 0, 0, 1, 0, 10, 100, 1, 0, 8, 0));
        tbl.push_back(mk(1, 20, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 11, 101, 0, 0, 7, 0));
        tbl.push_back(mk(1, 21, 0, 0, 0, 0, 0, 1,   1, 1, 1, 2, 12, 102, 0, 0, 7, 0));
        tbl.push_back(mk(1, 22, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 1, 0, 8, 0));
        // Drain 3..7 then 0..2 with pipelined issue/writeback
        tbl.push_back(mk(0,  0, 1, 3, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 1, 4, 1, 3, 203, 0, 0, 3, 0, 0, 0, 0, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 1, 5, 1, 4, 204, 1, 0, 3, 1, 3, 13, 203, 1, 0, 8, 0));
        tbl.push_back(mk(0,  0, 1, 6, 1, 5, 205, 1, 1, 3, 1, 4, 14, 204, 0, 0, 7, 0));
        tbl.push_back(mk(0,  0, 1, 7, 1, 6, 206, 1, 1, 3, 1, 5, 15, 205, 0, 0, 6, 0));
        tbl.push_back(mk(0,  0, 1, 0, 1, 7, 207, 1, 1, 3, 1, 6, 16, 206, 0, 0, 5, 0));
        tbl.push_back(mk(0,  0, 1, 1, 1, 0, 300, 1, 1, 3, 1, 7, 17, 207, 0, 0, 4, 0));
        tbl.push_back(mk(0,  0, 1, 2, 1, 1, 301, 1, 1, 3, 1, 0, 20, 300, 0, 0, 3, 0));
        tbl.push_back(mk(0,  0, 0, 0, 1, 2, 302, 1, 1, 3, 1, 1, 21, 301, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 1,   1, 3, 1, 2, 22, 302, 0, 0, 1, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0, 1, 0, 0));
        // Out-of-order writeback, in-order commit
        tbl.push_back(mk(1, 40, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 41, 0, 0, 0, 0, 0, 0,   1, 4, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0,  0, 1, 3, 0, 0, 0, 1,   1, 5, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 1, 4, 0, 0, 0, 1,   1, 5, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 0, 0, 1, 4, 32'hBEEF, 1, 1, 5, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 0, 0, 1, 3, 32'h1234, 1, 1, 5, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 1,   1, 5, 1, 3, 40, 32'h1234, 0, 0, 2, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 1,   1, 5, 1, 4, 41, 32'hBEEF, 0, 0, 1, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 0, 1, 0, 0));
        // Illegal writebacks: to PENDING, and issue+writeback same tag same cycle
        tbl.push_back(mk(1, 50, 0, 0, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0,  0, 0, 0, 1, 5, 32'hDEAD, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0,  0, 1, 5, 1, 5, 32'hCAFE, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   1, 6, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0,  0, 0, 0, 1, 5, 77, 0,  1, 6, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 1,   1, 6, 1, 5, 50, 77, 0, 0, 1, 1));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,   1, 6, 0, 0, 0, 0, 0, 1, 0, 1));

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ar, tbl[i].ad, tbl[i].iv, tbl[i].ia, tbl[i].wv, tbl[i].wa,
                  tbl[i].wd, tbl[i].cr, 1'b0);
            #1;
            chk_vec(i, tbl[i]);
            @(negedge clk);
        end

        // Flush with five entries in mixed states (6 RETIRED, 7 EXECUTE, 0..2 PENDING)
        drive(1, 60, 0, 0, 0, 0, 0, 0, 0); #1; chk("fl.alloc_addr0", 32'(alloc_addr), 6); @(negedge clk);
        drive(1, 61, 1, 6, 0, 0, 0, 0, 0); @(negedge clk);
        drive(1, 62, 1, 7, 1, 6, 32'h66, 0, 0); @(negedge clk);
        drive(1, 63, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
        drive(1, 64, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl.pre_count", 32'(count), 5);
        chk("fl.pre_commit_addr", 32'(commit_addr), 6);
        chk("fl.pre_commit_value", commit_value, 32'h66);
        chk("fl.pre_alloc_addr", 32'(alloc_addr), 3);
        @(negedge clk);
        drive(1, 70, 0, 0, 1, 7, 32'h5, 1, 1); #1;
        chk("fl.cyc_commit_valid", 32'(commit_valid), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl.post_count", 32'(count), 0);
        chk("fl.post_empty", 32'(empty), 1);
        chk("fl.post_commit_valid", 32'(commit_valid), 0);
        chk("fl.post_alloc_addr", 32'(alloc_addr), 0);
        chk("fl.post_wb_err", 32'(wb_err), 1);
        @(negedge clk);
        drive(1, 80, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl.realloc_count", 32'(count), 1);
        chk("fl.realloc_alloc_addr", 32'(alloc_addr), 1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("ar.count", 32'(count), 0);
        chk("ar.empty", 32'(empty), 1);
        chk("ar.full", 32'(full), 0);
        chk("ar.alloc_ready", 32'(alloc_ready), 1);
        chk("ar.alloc_addr", 32'(alloc_addr), 0);
        chk("ar.commit_valid", 32'(commit_valid), 0);
        chk("ar.wb_err", 32'(wb_err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
